ps2_matrix_kbd: RTL and testbench
=================================

Name: ps2_matrix_kbd

Overview:
- Parametrised PS/2-to-matrix keyboard emulator: receives PS/2 set-2 scan codes and holds a ROWS x COLS key-state matrix that the host machine scans in both directions (row-drive/column-sense and column-drive/row-sense).
- Extends the current keyboard block with:
  - runtime-configurable geometry;
  - E0-prefixed extended codes;
  - E1 (Pause) sequence swallowing;
  - an inter-bit timeout watchdog.
- Scan-code-to-position mapping is external, through a lookup port, so one block serves every machine variant (Radio-86RK, Specialist, MX).

Parameters:
- ROWS, 6, number of matrix rows.
- COLS, 12, number of matrix columns.
- FILT, 4, clk cycles ps2_clk must be stable before an edge is accepted.
- TIMEOUT, 100000, clk cycles without a ps2_clk falling edge before a partial frame is aborted.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- ps2_clk  in  1  PS/2 clock, asynchronous.
- ps2_dat  in  1  PS/2 data, asynchronous.
- map_code  out  9  {ext, byte} presented to the external mapping LUT.
- map_valid  in  1  LUT hit for map_code.
- map_row  in  $clog2(ROWS)  LUT row.
- map_col  in  $clog2(COLS)  LUT column.
- row_sel  in  ROWS  host row drive, active-low.
- col_out  out  COLS  column sense, active-low.
- col_sel  in  COLS  host column drive, active-low.
- row_out  out  ROWS  row sense, active-low.
- clear  in  1  synchronous release-all.
- key_event  out  1  one-cycle strobe: a mapped-or-unmapped key event was applied.
- key_code  out  9  {ext, byte} of the last event.
- key_break  out  1  1 = release, valid with key_event.
- frame_err  out  1  one-cycle strobe on a parity, start, stop or timeout fault.

Behaviour:
Reset values (while reset=0, asynchronous):
- Matrix all 0, so col_out and row_out are all 1s.
- key_event, key_break, frame_err = 0.
- key_code, map_code = 0.
- Receiver and decoder return to idle.

Receiver:
- ps2_clk and ps2_dat each pass through a 2-flop synchroniser.
- ps2_clk must then hold a new level FILT consecutive cycles before a change is accepted.
- On an accepted falling edge, ps2_dat is shifted in.
- Frame is 11 bits: start=0, 8 data bits LSB first, odd parity, stop=1.
- After bit 11, the frame is checked. Good frame → one-cycle byte_rdy. Bad frame → frame_err pulse, byte discarded.
- The idle counter resets on every accepted edge. It reaching TIMEOUT with 1-10 bits collected → frame_err pulse, bit count cleared. No error is raised when 0 bits are collected.

Decoder FSM (advances on byte_rdy):
- IDLE:
  - E0 → EXT.
  - F0 → BRK.
  - E1 → SKIP (load skip count 7).
  - AA, FA, FE, EE → ignored, stay in IDLE.
  - 00 or FF → frame_err pulse, stay in IDLE.
  - Any other byte → LOOKUP with ext=0, brk=0.
- EXT:
  - F0 → EXT_BRK.
  - 12 or 59 (fake shifts) → IDLE, dropped.
  - Other byte → LOOKUP with ext=1.
- BRK: any byte → LOOKUP with brk=1.
- EXT_BRK: 12 or 59 → IDLE; other byte → LOOKUP with ext=1, brk=1.
- SKIP: decrement count on each byte; return to IDLE when the count reaches 0.

LOOKUP and APPLY timing:
- Entering LOOKUP registers map_code = {ext, byte}.
- LOOKUP lasts exactly one cycle; the LUT is combinational and is sampled at the end of that cycle.
- Next cycle is APPLY:
  - key_event=1, key_code=map_code, key_break=brk.
  - If map_valid, state[map_row][map_col] <= ~brk.
  - Then return to IDLE.
- Latency: byte_rdy → matrix visible at the outputs = 2 cycles.
- map_row >= ROWS or map_col >= COLS → treated as a miss.
- Typematic repeats re-set an already-set bit; this is harmless.

Matrix outputs (combinational from state):
- col_out[c] = ~OR over r of (state[r][c] & ~row_sel[r]).
- row_out[r] = ~OR over c of (state[r][c] & ~col_sel[c]).

Boundary conditions:
- clear=1 zeroes the whole matrix next edge and wins over a simultaneous APPLY. key_event still pulses.
- A frame_err in a prefix state (EXT, BRK, EXT_BRK, SKIP) returns the FSM to IDLE.
- Reset mid-frame discards the partial frame; the matrix is cleared.

Decomposition:
- Package ps2_kbd_pkg holds:
  - decoder state enum (IDLE, EXT, BRK, EXT_BRK, SKIP, LOOKUP, APPLY);
  - byte constants: PFX_EXT=E0, PFX_BRK=F0, PFX_PAUSE=E1, and the ignore set;
  - PAUSE_SKIP=7.
- Sub-module ps2_rx: synchronisers, FILT glitch filter, 11-bit shifter, parity/framing check, TIMEOUT watchdog. Outputs byte, byte_rdy, frame_err.
- ps2_matrix_kbd contains ps2_rx, the decoder FSM, the matrix, and the output reduction.

Test Plan:
- Make then break of 1C, LUT maps 1C → row 2, col 8:
  - After make, row_sel=6'b111011 → col_out=12'hEFF.
  - With col_sel bit 8 low → row_out=6'b111011.
  - key_event fires with key_code=0x01C, key_break=0.
  - After F0 1C, col_out returns to 12'hFFF and key_break=1.
- E0 75 with LUT hit at row 0, col 9:
  - key_code=0x175, matrix bit set.
  - E0 12 produces no key_event.
- Frame 1C sent with wrong parity → frame_err one cycle, no key_event. A following good 1C frame is accepted.
- Five bits sent, then ps2_clk idle for TIMEOUT+10 cycles → frame_err, bit count cleared. A subsequent full 29 frame → key_event, key_code=0x029.
- Pause sequence E1 14 77 E1 F0 14 F0 77 → no key_event, FSM back in IDLE. A following 5A → key_event, key_code=0x05A.
- With 3 keys held, assert clear in the same cycle as a make APPLY → matrix all 0, key_event pulses once. Async reset mid-frame → all outputs at their reset values.

Source files
------------

// File: rtl/ps2_kbd_pkg.sv
// ps2_kbd_pkg
//   Shared types and constants for the PS/2-to-matrix keyboard emulator.
//   - dec_state_t : scan-code decoder states (exposed on the top-level debug port)
//   - PFX_*       : set-2 prefix bytes (extended, break, pause)
//   - PAUSE_SKIP  : bytes swallowed after the E1 pause prefix
//   - is_ignored / is_bad_code / is_fake_shift : byte classification helpers
package ps2_kbd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_SKIP    = 3'd4,
        ST_LOOKUP  = 3'd5,
        ST_APPLY   = 3'd6
    } dec_state_t;

    localparam logic [7:0] PFX_EXT   = 8'hE0;
    localparam logic [7:0] PFX_BRK   = 8'hF0;
    localparam logic [7:0] PFX_PAUSE = 8'hE1;

    // Keyboard-to-host status bytes that carry no key information
    localparam logic [7:0] CODE_BAT_OK = 8'hAA;
    localparam logic [7:0] CODE_ACK    = 8'hFA;
    localparam logic [7:0] CODE_RESEND = 8'hFE;
    localparam logic [7:0] CODE_ECHO   = 8'hEE;

    // Keyboard internal error / buffer overrun codes
    localparam logic [7:0] CODE_ERR_LO = 8'h00;
    localparam logic [7:0] CODE_ERR_HI = 8'hFF;

    // Shift make/break codes the keyboard injects around E0 keys
    localparam logic [7:0] CODE_FAKE_LSH = 8'h12;
    localparam logic [7:0] CODE_FAKE_RSH = 8'h59;

    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    function automatic logic is_ignored(input logic [7:0] b);
        return (b == CODE_BAT_OK) || (b == CODE_ACK) ||
               (b == CODE_RESEND) || (b == CODE_ECHO);
    endfunction

    function automatic logic is_bad_code(input logic [7:0] b);
        return (b == CODE_ERR_LO) || (b == CODE_ERR_HI);
    endfunction

    function automatic logic is_fake_shift(input logic [7:0] b);
        return (b == CODE_FAKE_LSH) || (b == CODE_FAKE_RSH);
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// ps2_rx
//   PS/2 device-to-host byte receiver.
//   Ports:
//     i_clk, i_reset (async, active-low)
//     i_ps2_clk, i_ps2_dat : raw asynchronous PS/2 lines
//     o_byte               : last good data byte
//     o_byte_rdy           : one-cycle strobe, o_byte valid
//     o_frame_err          : one-cycle strobe on start/parity/stop fault or timeout
//   Both lines are double-synchronised; ps2_clk must then hold a new level
//   for FILT cycles before the change is accepted. Data is sampled on
//   accepted falling edges. A partial frame left idle for TIMEOUT cycles
//   is aborted.
module ps2_rx #(
    parameter int FILT    = 4,
    parameter int TIMEOUT = 100000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_dat,
    output logic [7:0] o_byte,
    output logic       o_byte_rdy,
    output logic       o_frame_err
);

    localparam int FW = (FILT > 1) ? $clog2(FILT + 1) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [1:0]    r_clk_sync;
    logic [1:0]    r_dat_sync;
    logic          r_clk_filt;
    logic [FW-1:0] r_filt_cnt;
    logic [9:0]    r_shift;
    logic [3:0]    r_bitcnt;
    logic [TW-1:0] r_idle;

    logic          w_clk_s;
    logic          w_dat_s;
    logic          w_accept;
    logic          w_fall;
    logic [10:0]   w_frame;
    logic          w_good;
    logic          w_timeout;

    assign w_clk_s  = r_clk_sync[1];
    assign w_dat_s  = r_dat_sync[1];

    // The FILT-th consecutive cycle at the new level is the one that accepts it
    assign w_accept = (w_clk_s != r_clk_filt) && (r_filt_cnt == FW'(FILT - 1));
    assign w_fall   = w_accept && r_clk_filt;

    // Bits 0..9 already sit in r_shift (bit 0 = start); bit 10 is arriving now
    assign w_frame  = {w_dat_s, r_shift};
    assign w_good   = !w_frame[0] && w_frame[10] && (^w_frame[9:1]);

    assign w_timeout = (r_bitcnt != 4'd0) && (r_idle == TW'(TIMEOUT - 1)) && !w_accept;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_clk_sync  <= 2'b11;
            r_dat_sync  <= 2'b11;
            r_clk_filt  <= 1'b1;
            r_filt_cnt  <= '0;
            r_shift     <= '0;
            r_bitcnt    <= '0;
            r_idle      <= '0;
            o_byte      <= '0;
            o_byte_rdy  <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], i_ps2_clk};
            r_dat_sync  <= {r_dat_sync[0], i_ps2_dat};
            o_byte_rdy  <= 1'b0;
            o_frame_err <= 1'b0;

            if (w_clk_s == r_clk_filt) begin
                r_filt_cnt <= '0;
            end else if (w_accept) begin
                r_filt_cnt <= '0;
                r_clk_filt <= w_clk_s;
            end else begin
                r_filt_cnt <= r_filt_cnt + FW'(1);
            end

            if (w_accept || (r_bitcnt == 4'd0)) begin
                r_idle <= '0;
            end else begin
                r_idle <= r_idle + TW'(1);
            end

            if (w_fall) begin
                r_shift <= {w_dat_s, r_shift[9:1]};
                if (r_bitcnt == 4'd10) begin
                    r_bitcnt <= '0;
                    if (w_good) begin
                        o_byte     <= w_frame[8:1];
                        o_byte_rdy <= 1'b1;
                    end else begin
                        o_frame_err <= 1'b1;
                    end
                end else begin
                    r_bitcnt <= r_bitcnt + 4'd1;
                end
            end else if (w_timeout) begin
                o_frame_err <= 1'b1;
                r_bitcnt    <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_matrix_kbd.sv
// ps2_matrix_kbd
//   PS/2 set-2 keyboard to ROWS x COLS key matrix emulator.
//   Ports:
//     i_clk, i_reset (async, active-low)
//     i_ps2_clk, i_ps2_dat        : PS/2 lines
//     o_map_code                  : {ext, byte} to the external mapping LUT
//     i_map_valid/i_map_row/i_map_col : combinational LUT answer
//     i_row_sel -> o_col_out      : row drive / column sense, active-low
//     i_col_sel -> o_row_out      : column drive / row sense, active-low
//     i_clear                     : synchronous release of all keys
//     o_key_event/o_key_code/o_key_break : one-cycle key event report
//     o_frame_err                 : one-cycle receive/protocol fault strobe
//     o_dbg_state                 : current decoder state
//   Timing: byte_rdy -> LOOKUP (LUT sampled at its end) -> APPLY, where the
//   event strobe is high and the matrix update is already visible.
module ps2_matrix_kbd
    import ps2_kbd_pkg::*;
#(
    parameter int ROWS    = 6,
    parameter int COLS    = 12,
    parameter int FILT    = 4,
    parameter int TIMEOUT = 100000
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_ps2_clk,
    input  logic                    i_ps2_dat,
    output logic [8:0]              o_map_code,
    input  logic                    i_map_valid,
    input  logic [$clog2(ROWS)-1:0] i_map_row,
    input  logic [$clog2(COLS)-1:0] i_map_col,
    input  logic [ROWS-1:0]         i_row_sel,
    output logic [COLS-1:0]         o_col_out,
    input  logic [COLS-1:0]         i_col_sel,
    output logic [ROWS-1:0]         o_row_out,
    input  logic                    i_clear,
    output logic                    o_key_event,
    output logic [8:0]              o_key_code,
    output logic                    o_key_break,
    output logic                    o_frame_err,
    output logic [2:0]              o_dbg_state
);

    logic [7:0]             w_rx_byte;
    logic                   w_rx_rdy;
    logic                   w_rx_err;
    logic                   w_hit;
    logic [COLS-1:0]        w_col_out;
    logic [ROWS-1:0]        w_row_out;

    dec_state_t             r_state;
    logic                   r_brk;
    logic [2:0]             r_skip;
    logic [8:0]             r_map_code;
    logic                   r_key_event;
    logic [8:0]             r_key_code;
    logic                   r_key_break;
    logic                   r_frame_err;
    logic [ROWS-1:0][COLS-1:0] r_matrix;

    ps2_rx #(
        .FILT    (FILT),
        .TIMEOUT (TIMEOUT)
    ) u_rx (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_ps2_clk   (i_ps2_clk),
        .i_ps2_dat   (i_ps2_dat),
        .o_byte      (w_rx_byte),
        .o_byte_rdy  (w_rx_rdy),
        .o_frame_err (w_rx_err)
    );

    // Out-of-range LUT coordinates count as a miss
    assign w_hit = i_map_valid && (int'(i_map_row) < ROWS) && (int'(i_map_col) < COLS);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= ST_IDLE;
            r_brk       <= 1'b0;
            r_skip      <= '0;
            r_map_code  <= '0;
            r_key_event <= 1'b0;
            r_key_code  <= '0;
            r_key_break <= 1'b0;
            r_frame_err <= 1'b0;
            r_matrix    <= '0;
        end else begin
            r_key_event <= 1'b0;
            r_frame_err <= w_rx_err;

            case (r_state)
                ST_IDLE: begin
                    if (w_rx_rdy) begin
                        if (w_rx_byte == PFX_EXT) begin
                            r_state <= ST_EXT;
                        end else if (w_rx_byte == PFX_BRK) begin
                            r_state <= ST_BRK;
                        end else if (w_rx_byte == PFX_PAUSE) begin
                            r_state <= ST_SKIP;
                            r_skip  <= PAUSE_SKIP;
                        end else if (is_ignored(w_rx_byte)) begin
                            r_state <= ST_IDLE;
                        end else if (is_bad_code(w_rx_byte)) begin
                            r_frame_err <= 1'b1;
                        end else begin
                            r_map_code <= {1'b0, w_rx_byte};
                            r_brk      <= 1'b0;
                            r_state    <= ST_LOOKUP;
                        end
                    end
                end
                ST_EXT: begin
                    if (w_rx_err) begin
                        r_state <= ST_IDLE;
                    end else if (w_rx_rdy) begin
                        if (w_rx_byte == PFX_BRK) begin
                            r_state <= ST_EXT_BRK;
                        end else if (is_fake_shift(w_rx_byte)) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_map_code <= {1'b1, w_rx_byte};
                            r_brk      <= 1'b0;
                            r_state    <= ST_LOOKUP;
                        end
                    end
                end
                ST_BRK: begin
                    if (w_rx_err) begin
                        r_state <= ST_IDLE;
                    end else if (w_rx_rdy) begin
                        r_map_code <= {1'b0, w_rx_byte};
                        r_brk      <= 1'b1;
                        r_state    <= ST_LOOKUP;
                    end
                end
                ST_EXT_BRK: begin
                    if (w_rx_err) begin
                        r_state <= ST_IDLE;
                    end else if (w_rx_rdy) begin
                        if (is_fake_shift(w_rx_byte)) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_map_code <= {1'b1, w_rx_byte};
                            r_brk      <= 1'b1;
                            r_state    <= ST_LOOKUP;
                        end
                    end
                end
                ST_SKIP: begin
                    if (w_rx_err) begin
                        r_state <= ST_IDLE;
                    end else if (w_rx_rdy) begin
                        r_skip <= r_skip - 3'd1;
                        if (r_skip == 3'd1) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_LOOKUP: begin
                    // LUT answer for r_map_code is sampled here; results show in APPLY
                    r_key_event <= 1'b1;
                    r_key_code  <= r_map_code;
                    r_key_break <= r_brk;
                    if (w_hit) begin
                        r_matrix[i_map_row][i_map_col] <= ~r_brk;
                    end
                    r_state <= ST_APPLY;
                end
                ST_APPLY: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // Release-all overrides any simultaneous key update
            if (i_clear) begin
                r_matrix <= '0;
            end
        end
    end

    always_comb begin
        w_col_out = '1;
        w_row_out = '1;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (r_matrix[r][c] && !i_row_sel[r]) begin
                    w_col_out[c] = 1'b0;
                end
                if (r_matrix[r][c] && !i_col_sel[c]) begin
                    w_row_out[r] = 1'b0;
                end
            end
        end
    end

    assign o_col_out   = w_col_out;
    assign o_row_out   = w_row_out;
    assign o_map_code  = r_map_code;
    assign o_key_event = r_key_event;
    assign o_key_code  = r_key_code;
    assign o_key_break = r_key_break;
    assign o_frame_err = r_frame_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ps2_matrix_kbd.sv
// tb_ps2_matrix_kbd
//   Bench for ps2_matrix_kbd: a PS/2 device model drives frames, a small LUT
//   answers map lookups, and observed key events are checked against an
//   expected queue filled when each key's frame is sent.
module tb_ps2_matrix_kbd;
    import ps2_kbd_pkg::*;

    localparam int ROWS    = 6;
    localparam int COLS    = 12;
    localparam int TIMEOUT = 2000;

    logic        clk;
    logic        rst_n;
    logic        ps2_clk;
    logic        ps2_dat;
    logic [8:0]  map_code;
    logic        map_valid;
    logic [2:0]  map_row;
    logic [3:0]  map_col;
    logic [5:0]  row_sel;
    logic [11:0] col_out;
    logic [11:0] col_sel;
    logic [5:0]  row_out;
    logic        clear;
    logic        key_event;
    logic [8:0]  key_code;
    logic        key_break;
    logic        frame_err;
    logic [2:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int n_kev    = 0;
    int n_ferr   = 0;

    logic [9:0] exp_q[$];
    logic [9:0] act_q[$];

    ps2_matrix_kbd #(
        .ROWS    (ROWS),
        .COLS    (COLS),
        .FILT    (4),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst_n),
        .i_ps2_clk   (ps2_clk),
        .i_ps2_dat   (ps2_dat),
        .o_map_code  (map_code),
        .i_map_valid (map_valid),
        .i_map_row   (map_row),
        .i_map_col   (map_col),
        .i_row_sel   (row_sel),
        .o_col_out   (col_out),
        .i_col_sel   (col_sel),
        .o_row_out   (row_out),
        .i_clear     (clear),
        .o_key_event (key_event),
        .o_key_code  (key_code),
        .o_key_break (key_break),
        .o_frame_err (frame_err),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- mapping LUT ----------------
    always_comb begin
        map_valid = 1'b0;
        map_row   = 3'd0;
        map_col   = 4'd0;
        case (map_code)
            9'h01C: begin map_valid = 1'b1; map_row = 3'd2; map_col = 4'd8;  end
            9'h175: begin map_valid = 1'b1; map_row = 3'd0; map_col = 4'd9;  end
            9'h029: begin map_valid = 1'b1; map_row = 3'd5; map_col = 4'd0;  end
            9'h05A: begin map_valid = 1'b1; map_row = 3'd3; map_col = 4'd11; end
            9'h171: begin map_valid = 1'b1; map_row = 3'd6; map_col = 4'd1;  end
            default: begin map_valid = 1'b0; end
        endcase
    end

    // ---------------- output monitor ----------------
    always @(negedge clk) begin
        if (rst_n && key_event) begin
            act_q.push_back({key_break, key_code});
            n_kev++;
        end
        if (rst_n && frame_err) begin
            n_ferr++;
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, n_checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad_par);
        return {1'b1, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ps2_dat = f[i];
            repeat (15) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (15) @(negedge clk);
            ps2_clk = 1'b1;
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(mk_frame(b, 1'b0), 11);
    endtask

    task automatic press(input logic ext, input logic [7:0] code, input logic brk);
        if (ext) send_byte(PFX_EXT);
        if (brk) send_byte(PFX_BRK);
        exp_q.push_back({brk, ext, code});
        send_byte(code);
    endtask

    task automatic sb_drain(input string name);
        logic [9:0] e;
        logic [9:0] a;
        repeat (5) @(negedge clk);
        while (exp_q.size() > 0 || act_q.size() > 0) begin
            if (act_q.size() == 0) begin
                e = exp_q.pop_front();
                n_checks++;
                n_fail++;
                $display("FAIL %s: missing key event, expected {brk,code}=0x%0h", name, e);
            end else if (exp_q.size() == 0) begin
                a = act_q.pop_front();
                n_checks++;
                n_fail++;
                $display("FAIL %s: unexpected key event {brk,code}=0x%0h, expected none", name, a);
            end else begin
                e = exp_q.pop_front();
                a = act_q.pop_front();
                check(name, 32'(a), 32'(e));
            end
        end
    endtask

    typedef struct {
        logic        ext;
        logic [7:0]  code;
        logic [5:0]  row_sel;
        logic [11:0] exp_col;
        logic [11:0] col_sel;
        logic [5:0]  exp_row;
    } vec_t;

    vec_t vecs[6];

    // ---------------- main sequence ----------------
    initial begin
        int ferr0;
        int kev0;
        int k;

        vecs[0] = '{1'b0, 8'h1C, 6'b111011, 12'hEFF, 12'hEFF, 6'b111011};
        vecs[1] = '{1'b1, 8'h75, 6'b111110, 12'hDFF, 12'hDFF, 6'b111110};
        vecs[2] = '{1'b0, 8'h29, 6'b011111, 12'hFFE, 12'hFFE, 6'b011111};
        vecs[3] = '{1'b0, 8'h5A, 6'b110111, 12'h7FF, 12'h7FF, 6'b110111};
        vecs[4] = '{1'b0, 8'h44, 6'b000000, 12'hFFF, 12'h000, 6'b111111};
        vecs[5] = '{1'b1, 8'h71, 6'b000000, 12'hFFF, 12'h000, 6'b111111};

        rst_n   = 1'b0;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        row_sel = '0;
        col_sel = '0;
        clear   = 1'b0;

        repeat (5) @(negedge clk);
        check("reset_col_out", 32'(col_out), 32'hFFF);
        check("reset_row_out", 32'(row_out), 32'h3F);
        check("reset_key_event", 32'(key_event), 0);
        check("reset_key_code", 32'(key_code), 0);
        check("reset_map_code", 32'(map_code), 0);
        check("reset_frame_err", 32'(frame_err), 0);
        rst_n   = 1'b1;
        row_sel = '1;
        col_sel = '1;
        repeat (10) @(negedge clk);

        // Table: make, probe both scan directions, break, probe again
        for (int i = 0; i < 6; i++) begin
            press(vecs[i].ext, vecs[i].code, 1'b0);
            sb_drain($sformatf("make_event_%0d", i));
            check($sformatf("map_code_%0d", i), 32'(map_code), 32'({vecs[i].ext, vecs[i].code}));
            row_sel = vecs[i].row_sel;
            col_sel = vecs[i].col_sel;
            @(negedge clk);
            check($sformatf("make_col_out_%0d", i), 32'(col_out), 32'(vecs[i].exp_col));
            check($sformatf("make_row_out_%0d", i), 32'(row_out), 32'(vecs[i].exp_row));
            press(vecs[i].ext, vecs[i].code, 1'b1);
            sb_drain($sformatf("break_event_%0d", i));
            check($sformatf("break_col_out_%0d", i), 32'(col_out), 32'hFFF);
            row_sel = '1;
            col_sel = '1;
        end

        // Fake shifts after E0 and E0 F0 are dropped
        send_byte(8'hE0);
        send_byte(8'h12);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h59);
        sb_drain("fake_shift");
        check("fake_shift_state", 32'(dbg_state), 32'(ST_IDLE));

        // Status bytes ignored, error byte flags once
        send_byte(8'hAA);
        ferr0 = n_ferr;
        send_byte(8'h00);
        check("err_code_00", 32'(n_ferr - ferr0), 1);
        sb_drain("status_bytes");

        // Bad parity frame: one-cycle frame_err, byte dropped, next frame fine
        ferr0 = n_ferr;
        send_bits(mk_frame(8'h1C, 1'b1), 11);
        check("bad_parity_err", 32'(n_ferr - ferr0), 1);
        sb_drain("bad_parity_no_event");
        press(1'b0, 8'h1C, 1'b0);
        sb_drain("after_parity_make");
        press(1'b0, 8'h1C, 1'b1);
        sb_drain("after_parity_break");

        // Partial frame then idle past TIMEOUT
        ferr0 = n_ferr;
        send_bits(mk_frame(8'h29, 1'b0), 5);
        repeat (TIMEOUT + 10) @(negedge clk);
        check("timeout_err", 32'(n_ferr - ferr0), 1);
        press(1'b0, 8'h29, 1'b0);
        sb_drain("after_timeout_make");
        press(1'b0, 8'h29, 1'b1);
        sb_drain("after_timeout_break");

        // Pause sequence fully swallowed
        send_byte(8'hE1);
        send_byte(8'h14);
        send_byte(8'h77);
        send_byte(8'hE1);
        send_byte(8'hF0);
        send_byte(8'h14);
        send_byte(8'hF0);
        send_byte(8'h77);
        sb_drain("pause_no_event");
        check("pause_state_idle", 32'(dbg_state), 32'(ST_IDLE));
        press(1'b0, 8'h5A, 1'b0);
        sb_drain("after_pause_make");
        press(1'b0, 8'h5A, 1'b1);
        sb_drain("after_pause_break");

        // Three keys held, then clear coincident with a make update
        press(1'b0, 8'h1C, 1'b0);
        press(1'b0, 8'h29, 1'b0);
        press(1'b0, 8'h5A, 1'b0);
        sb_drain("three_keys");
        row_sel = '0;
        @(negedge clk);
        check("three_keys_col_out", 32'(col_out), 32'h6FE);
        kev0 = n_kev;
        fork
            press(1'b1, 8'h75, 1'b0);
            begin
                k = 0;
                while (dbg_state != ST_LOOKUP && k < 2000) begin
                    @(negedge clk);
                    k++;
                end
                check("clear_lookup_seen", 32'(k < 2000), 1);
                clear = 1'b1;
                @(negedge clk);
                clear = 1'b0;
            end
        join
        sb_drain("clear_event");
        check("clear_event_once", 32'(n_kev - kev0), 1);
        col_sel = '0;
        @(negedge clk);
        check("clear_col_out", 32'(col_out), 32'hFFF);
        check("clear_row_out", 32'(row_out), 32'h3F);
        col_sel = '1;

        // Async reset in the middle of a frame with a key held
        press(1'b0, 8'h1C, 1'b0);
        sb_drain("pre_reset_make");
        @(negedge clk);
        check("pre_reset_col_out", 32'(col_out), 32'hEFF);
        send_bits(mk_frame(8'h29, 1'b0), 5);
        #3;
        rst_n = 1'b0;
        #1;
        check("midreset_col_out", 32'(col_out), 32'hFFF);
        check("midreset_row_out", 32'(row_out), 32'h3F);
        check("midreset_key_event", 32'(key_event), 0);
        check("midreset_key_code", 32'(key_code), 0);
        check("midreset_map_code", 32'(map_code), 0);
        check("midreset_state", 32'(dbg_state), 32'(ST_IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        ferr0 = n_ferr;
        press(1'b0, 8'h5A, 1'b0);
        sb_drain("post_reset_make");
        check("post_reset_no_err", 32'(n_ferr - ferr0), 0);
        @(negedge clk);
        check("post_reset_col_out", 32'(col_out), 32'h7FF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
